// File: rtl/prog_loader.sv
// Instruction-memory loader: turns a length-prefixed little-endian byte stream
// into one-cycle word writes and holds the CPU in reset until a clean load ends.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        BYTE_VALID,
  input  logic [7:0]  BYTE_DATA,
  output logic        BYTE_READY,
  output logic        IM_WE,
  output logic [31:0] IM_ADDR,
  output logic [31:0] IM_WD,
  output logic        CPU_RST,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS + 1);
  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE
  } state_t;

  state_t             state, next_state;
  logic [15:0]        count;
  logic [IDX_W-1:0]   word_idx;
  logic [IDX_W-1:0]   word_next;
  logic [1:0]         byte_idx;
  logic [23:0]        asm_lo;
  logic               accept;
  logic [15:0]        hdr_count;
  logic               too_long;
  logic               last_word;

  assign accept    = BYTE_VALID && BYTE_READY;
  assign hdr_count = {BYTE_DATA, count[7:0]};
  assign too_long  = {1'b0, hdr_count} > DEPTH_LIM;
  assign word_next = word_idx + IDX_W'(1);
  assign last_word = 16'(word_next) == count;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    BYTE_READY = 1'b0;
    IM_WE      = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      S_IDLE: if (START) next_state = S_HDR0;
      S_HDR0: begin
        BYTE_READY = 1'b1;
        BUSY       = 1'b1;
        if (accept) next_state = S_HDR1;
      end
      S_HDR1: begin
        BYTE_READY = 1'b1;
        BUSY       = 1'b1;
        if (accept) begin
          if (hdr_count == 16'd0 || too_long) next_state = S_DONE;
          else                                next_state = S_DATA;
        end
      end
      S_DATA: begin
        BYTE_READY = 1'b1;
        BUSY       = 1'b1;
        if (accept && byte_idx == 2'd3) next_state = S_WRITE;
      end
      S_WRITE: begin
        IM_WE      = 1'b1;
        BUSY       = 1'b1;
        next_state = last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        DONE = 1'b1;
        if (START) next_state = S_HDR0;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // The CPU is released only while parked in DONE after an error-free load.
  assign CPU_RST = !(state == S_DONE && !ERR);

  // Write address/data are captured on the 4th byte so they stay stable
  // between strobes while the next word is assembled in asm_lo.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_lo   <= '0;
      IM_ADDR  <= '0;
      IM_WD    <= '0;
      ERR      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (START) ERR <= 1'b0;
        S_HDR0: if (accept) count[7:0] <= BYTE_DATA;
        S_HDR1: if (accept) begin
          count    <= hdr_count;
          word_idx <= '0;
          byte_idx <= '0;
          ERR      <= too_long;
        end
        S_DATA: if (accept) begin
          byte_idx <= byte_idx + 2'd1;
          case (byte_idx)
            2'd0: asm_lo[7:0]   <= BYTE_DATA;
            2'd1: asm_lo[15:8]  <= BYTE_DATA;
            2'd2: asm_lo[23:16] <= BYTE_DATA;
            default: begin
              IM_WD   <= {BYTE_DATA, asm_lo};
              IM_ADDR <= BASE_ADDR + (32'(word_idx) << 2);
            end
          endcase
        end
        S_WRITE: begin
          word_idx <= word_next;
          byte_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed byte streams push expected writes,
// a negedge monitor pops and compares every IM_WE strobe.
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        BYTE_VALID = 1'b0;
  logic [7:0]  BYTE_DATA = 8'h00;
  logic        BYTE_READY;
  logic        IM_WE;
  logic [31:0] IM_ADDR;
  logic [31:0] IM_WD;
  logic        CPU_RST;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int checks = 0;
  int errors = 0;
  int writeCount = 0;
  logic [63:0] expQ[$];

  prog_loader dut (
    .CLK(CLK), .RST(RST), .START(START),
    .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA), .BYTE_READY(BYTE_READY),
    .IM_WE(IM_WE), .IM_ADDR(IM_ADDR), .IM_WD(IM_WD),
    .CPU_RST(CPU_RST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Monitor: every write strobe must match the oldest expected {addr, data}.
  always @(negedge CLK) begin
    if (!RST && IM_WE) begin
      logic [63:0] e;
      writeCount++;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write addr=%h wd=%h required none", IM_ADDR, IM_WD);
      end else begin
        e = expQ.pop_front();
        if ({IM_ADDR, IM_WD} !== e) begin
          errors++;
          $display("[TB] FAIL write addr=%h wd=%h required addr=%h wd=%h",
                   IM_ADDR, IM_WD, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic pulseStart();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // Streams bytes; with throttle, BYTE_VALID drops for a cycle before each byte.
  task automatic applyStimulus(input logic [7:0] bytes[$], input bit throttle);
    foreach (bytes[i]) begin
      int n = 0;
      if (throttle) begin
        BYTE_VALID = 1'b0;
        @(posedge CLK); #1;
      end
      BYTE_VALID = 1'b1;
      BYTE_DATA  = bytes[i];
      while (!BYTE_READY && n < 50) begin
        @(posedge CLK); #1;
        n++;
      end
      if (n >= 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL byte_timeout index=%0d actual=not_ready required=ready", i);
        BYTE_VALID = 1'b0;
        return;
      end
      @(posedge CLK); #1;
    end
    BYTE_VALID = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!DONE && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput(name, {31'd0, DONE}, 32'd1);
  endtask

  initial begin
    logic [7:0] twoWords[$];
    logic [7:0] hdrZero[$];
    logic [7:0] hdrOver[$];
    logic [7:0] partial[$];
    logic [7:0] oneWord[$];
    int w0;

    twoWords = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    hdrZero  = '{8'h00, 8'h00};
    hdrOver  = '{8'h01, 8'h01};
    partial  = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    oneWord  = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    // Reset
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_ready",   {31'd0, BYTE_READY}, 32'd0);
    checkOutput("rst_we",      {31'd0, IM_WE},      32'd0);
    checkOutput("rst_cpu_rst", {31'd0, CPU_RST},    32'd1);
    checkOutput("rst_done",    {31'd0, DONE},       32'd0);
    checkOutput("rst_err",     {31'd0, ERR},        32'd0);
    checkOutput("rst_busy",    {31'd0, BUSY},       32'd0);
    checkOutput("rst_addr",    IM_ADDR,             32'h0);
    checkOutput("rst_wd",      IM_WD,               32'h0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Two-word load, valid held high
    pulseStart();
    checkOutput("load_busy", {31'd0, BUSY}, 32'd1);
    expQ.push_back({32'h0000_0000, 32'h00A0_0513});
    expQ.push_back({32'h0000_0004, 32'h00B0_0593});
    applyStimulus(twoWords, 1'b0);
    waitDone("load_done");
    checkOutput("load_cpu_rst", {31'd0, CPU_RST}, 32'd0);
    checkOutput("load_busy_end", {31'd0, BUSY}, 32'd0);
    checkOutput("load_err", {31'd0, ERR}, 32'd0);
    checkOutput("load_ready_done", {31'd0, BYTE_READY}, 32'd0);
    checkOutput("load_pending", expQ.size(), 32'd0);
    checkOutput("load_writes", writeCount, 32'd2);

    // Throttled source, restart from DONE
    pulseStart();
    checkOutput("restart_cpu_rst", {31'd0, CPU_RST}, 32'd1);
    checkOutput("restart_done", {31'd0, DONE}, 32'd0);
    expQ.push_back({32'h0000_0000, 32'h00A0_0513});
    expQ.push_back({32'h0000_0004, 32'h00B0_0593});
    applyStimulus(twoWords, 1'b1);
    waitDone("thr_done");
    checkOutput("thr_cpu_rst", {31'd0, CPU_RST}, 32'd0);
    checkOutput("thr_pending", expQ.size(), 32'd0);
    checkOutput("thr_writes", writeCount, 32'd4);

    // Zero length
    pulseStart();
    applyStimulus(hdrZero, 1'b0);
    waitDone("zero_done");
    checkOutput("zero_err", {31'd0, ERR}, 32'd0);
    checkOutput("zero_cpu_rst", {31'd0, CPU_RST}, 32'd0);
    checkOutput("zero_writes", writeCount, 32'd4);

    // Overflow: count 257 exceeds capacity
    pulseStart();
    applyStimulus(hdrOver, 1'b0);
    waitDone("over_done");
    checkOutput("over_err", {31'd0, ERR}, 32'd1);
    checkOutput("over_cpu_rst", {31'd0, CPU_RST}, 32'd1);
    BYTE_VALID = 1'b1;
    BYTE_DATA  = 8'h55;
    repeat (4) @(posedge CLK);
    #1;
    checkOutput("over_ready", {31'd0, BYTE_READY}, 32'd0);
    checkOutput("over_hold_done", {31'd0, DONE}, 32'd1);
    BYTE_VALID = 1'b0;
    checkOutput("over_writes", writeCount, 32'd4);

    // Abort mid-load with reset, then reload
    w0 = writeCount;
    pulseStart();
    checkOutput("abort_err_clr", {31'd0, ERR}, 32'd0);
    expQ.push_back({32'h0000_0000, 32'h00A0_0513});
    applyStimulus(partial, 1'b0);
    repeat (3) @(posedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    checkOutput("abort_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("abort_cpu_rst", {31'd0, CPU_RST}, 32'd1);
    checkOutput("abort_done", {31'd0, DONE}, 32'd0);
    checkOutput("abort_writes", writeCount - w0, 32'd1);
    checkOutput("abort_pending", expQ.size(), 32'd0);

    pulseStart();
    expQ.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    applyStimulus(oneWord, 1'b0);
    waitDone("reload_done");
    checkOutput("reload_cpu_rst", {31'd0, CPU_RST}, 32'd0);
    checkOutput("reload_pending", expQ.size(), 32'd0);
    checkOutput("reload_wd_hold", IM_WD, 32'hDEAD_BEEF);

    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
